// File: rtl/update_weight_scheduler.sv
// Weight-update pass sequencer: walks output, hidden-2, hidden-1 weights, feeds update_weight, writes results back.
// Optional UPDATE_WEIGHT_SCHED_PAUSE_EN adds i_pause to stall read issue.
module update_weight_scheduler #(
    parameter int DATA_WIDTH                    = 32,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int ADDR_WIDTH                    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
`ifdef UPDATE_WEIGHT_SCHED_PAUSE_EN
    input  logic                  i_pause,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error_rd_en,
    output logic [ADDR_WIDTH-1:0] o_error_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_error_rd_data,
    output logic                  o_weight_rd_en,
    output logic [1:0]            o_weight_rd_sel,
    output logic [ADDR_WIDTH-1:0] o_weight_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_weight_rd_data,
    output logic                  o_uw_valid,
    output logic [DATA_WIDTH-1:0] o_uw_weight,
    output logic [DATA_WIDTH-1:0] o_uw_error,
    input  logic                  i_uw_valid,
    input  logic [DATA_WIDTH-1:0] i_uw_new_weight,
    output logic                  o_weight_wr_en,
    output logic [1:0]            o_weight_wr_sel,
    output logic [ADDR_WIDTH-1:0] o_weight_wr_addr,
    output logic [DATA_WIDTH-1:0] o_weight_wr_data,
    output logic                  o_seq_err
);
    localparam int N_OUT = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
    localparam int N_H2  = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
    localparam int N_H1  = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);

    typedef enum logic [2:0] {S_IDLE, S_OUT, S_HID2, S_HID1, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_gaddr;
    logic [ADDR_WIDTH-1:0] rd_laddr;
    logic [1:0]            rd_sel;
    logic [1:0]            wr_lsel;
    logic [ADDR_WIDTH-1:0] wr_laddr;
    logic [10:0]           outstanding;
    logic                  uw_vld;
    logic                  pause;
    logic                  rd_fire;
    logic                  start_acc;
    logic                  ret_acc;

    function automatic logic [ADDR_WIDTH-1:0] layer_last(input logic [1:0] sel);
        case (sel)
            2'd0:    return ADDR_WIDTH'(N_OUT - 1);
            2'd1:    return ADDR_WIDTH'(N_H2 - 1);
            default: return ADDR_WIDTH'(N_H1 - 1);
        endcase
    endfunction

`ifdef UPDATE_WEIGHT_SCHED_PAUSE_EN
    assign pause = i_pause;
`else
    assign pause = 1'b0;
`endif

    always_comb begin
        rd_sel = 2'd0;
        case (state)
            S_HID2:  rd_sel = 2'd1;
            S_HID1:  rd_sel = 2'd2;
            default: rd_sel = 2'd0;
        endcase
    end

    assign start_acc = (state == S_IDLE) && i_start;
    assign rd_fire   = ((state == S_OUT) || (state == S_HID2) || (state == S_HID1)) && !pause;
    // A return with nothing outstanding is a sequencing fault and must not produce a write.
    assign ret_acc   = i_uw_valid && (outstanding != '0);

    assign o_busy           = (state == S_OUT) || (state == S_HID2) || (state == S_HID1) || (state == S_DRAIN);
    assign o_done           = (state == S_DONE);
    assign o_error_rd_en    = rd_fire;
    assign o_weight_rd_en   = rd_fire;
    assign o_error_rd_addr  = rd_gaddr;
    assign o_weight_rd_sel  = rd_sel;
    assign o_weight_rd_addr = rd_laddr;
    assign o_uw_valid       = uw_vld;
    assign o_uw_weight      = uw_vld ? i_weight_rd_data : '0;
    assign o_uw_error       = uw_vld ? i_error_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_gaddr <= '0;
            rd_laddr <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    state    <= S_OUT;
                    rd_gaddr <= '0;
                    rd_laddr <= '0;
                end
                S_OUT, S_HID2, S_HID1: if (rd_fire) begin
                    rd_gaddr <= rd_gaddr + 1'b1;
                    if (rd_laddr == layer_last(rd_sel)) begin
                        rd_laddr <= '0;
                        state    <= (state == S_OUT) ? S_HID2 : (state == S_HID2) ? S_HID1 : S_DRAIN;
                    end else begin
                        rd_laddr <= rd_laddr + 1'b1;
                    end
                end
                // uw_vld covers the last read's feed cycle, not yet reflected in outstanding.
                S_DRAIN: if (outstanding == '0 && !uw_vld) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uw_vld           <= 1'b0;
            outstanding      <= '0;
            o_seq_err        <= 1'b0;
            o_weight_wr_en   <= 1'b0;
            o_weight_wr_sel  <= '0;
            o_weight_wr_addr <= '0;
            o_weight_wr_data <= '0;
            wr_lsel          <= '0;
            wr_laddr         <= '0;
        end else begin
            uw_vld         <= rd_fire;
            o_weight_wr_en <= ret_acc;
            if (uw_vld && !ret_acc && !(i_uw_valid && outstanding == '0))
                outstanding <= outstanding + 11'd1;
            else if (!uw_vld && ret_acc)
                outstanding <= outstanding - 11'd1;

            if (start_acc)
                o_seq_err <= 1'b0;
            else if (i_uw_valid && outstanding == '0)
                o_seq_err <= 1'b1;

            if (start_acc) begin
                wr_lsel  <= '0;
                wr_laddr <= '0;
            end else if (ret_acc) begin
                o_weight_wr_data <= i_uw_new_weight;
                o_weight_wr_sel  <= wr_lsel;
                o_weight_wr_addr <= wr_laddr;
                if (wr_laddr == layer_last(wr_lsel)) begin
                    wr_laddr <= '0;
                    wr_lsel  <= wr_lsel + 2'd1;
                end else begin
                    wr_laddr <= wr_laddr + 1'b1;
                end
            end
        end
    end
endmodule
